// File: rtl/rcon_seq.sv
// Sequential AES round-constant generator: holds the current Rcon byte and steps it by GF(2^8)
// doubling (or halving in inverse mode, built only when RCON_INVERSE_EN is defined).
module rcon_seq #(
  parameter int unsigned ROUNDS    = 10,
  parameter int unsigned WORD_SIZE = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     dir,
  input  logic                     step,
  output logic [$clog2(ROUNDS):0]  round,
  output logic [WORD_SIZE-1:0]     rcon,
  output logic                     valid,
  output logic                     last,
  output logic                     done
);

  localparam int unsigned RW = $clog2(ROUNDS) + 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e         state;
  logic [7:0]     rc;
  logic [RW-1:0]  rnd;
  logic           dr;
  logic [7:0]     rc_init;
  logic [7:0]     rc_back;
  logic [RW-1:0]  rnd_init;

  function automatic logic [7:0] fwd_step(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

`ifdef RCON_INVERSE_EN
  function automatic logic [7:0] rc_last_calc();
    logic [7:0] b;
    b = 8'h01;
    for (int unsigned i = 1; i < ROUNDS; i++) begin
      b = fwd_step(b);
    end
    return b;
  endfunction

  localparam logic [7:0] RC_LAST = rc_last_calc();

  // Direction is captured with load and held for the whole sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      dr <= 1'b0;
    end else if (load) begin
      dr <= dir;
    end else if (step && last) begin
      dr <= 1'b0;
    end
  end

  assign rc_init  = dir ? RC_LAST : 8'h01;
  assign rnd_init = dir ? RW'(ROUNDS) : RW'(1);
  assign rc_back  = rc[0] ? (((rc ^ 8'h1B) >> 1) | 8'h80) : (rc >> 1);
`else
  logic unused_dir;

  assign unused_dir = dir;
  assign dr         = 1'b0;
  assign rc_init    = 8'h01;
  assign rnd_init   = RW'(1);
  assign rc_back    = rc;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= StIdle;
      rc    <= 8'h00;
      rnd   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        // Restart wins over step and silently aborts any running sequence.
        state <= StRun;
        rc    <= rc_init;
        rnd   <= rnd_init;
      end else if (step && state == StRun) begin
        if (last) begin
          state <= StIdle;
          rc    <= 8'h00;
          rnd   <= '0;
          done  <= 1'b1;
        end else if (dr) begin
          rc  <= rc_back;
          rnd <= rnd - RW'(1);
        end else begin
          rc  <= fwd_step(rc);
          rnd <= rnd + RW'(1);
        end
      end
    end
  end

  assign valid = (state == StRun);
  assign round = valid ? rnd : '0;
  assign rcon  = valid ? (WORD_SIZE'(rc) << (WORD_SIZE - 8)) : '0;
  assign last  = valid && (dr ? (rnd == RW'(1)) : (rnd == RW'(ROUNDS)));

endmodule
